dout_seq_gen: RTL and testbench

DOUT_SEQ_GEN -- requirements
Module: dout_seq_gen

---
 rtl/dout_seq_gen.sv | 169 ++++++++++++++++
 tb/tb_dout_seq_gen.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dout_seq_gen.sv
// Pattern-memory driven parallel data sequencer.
// Words are played out of a small register-array memory with a derived bit
// clock (clk), a frame sync on word 0, and optional looping and
// post-sequence clearing of dout.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for a start; outputs hold, done low
// RUN    | playing words out, one per two divider ticks
// FINISH | single-cycle wrap-up: done high, clk/syn/dout cleanup
module dout_seq_gen #(
    parameter int DW    = 8,
    parameter int DEPTH = 1024,
    parameter int AW    = 10,
    parameter int DIVW  = 5
) (
    input  logic            clk_in,
    input  logic            rst_n,
    input  logic            trig,
    input  logic            abort,
    input  logic            loop_mode,
    input  logic            clr_mode,
    input  logic            clr_2_one,
    input  logic [AW-1:0]   seq_length,
    input  logic [DIVW-1:0] div_base,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [DW-1:0]   wr_data,
    output logic            clk,
    output logic [DW-1:0]   dout,
    output logic            syn,
    output logic            busy,
    output logic            done
);

    localparam int MW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]   DEPTH_W  = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST_MAX = AW'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    state_t          state;
    logic [DW-1:0]   mem [DEPTH];
    logic            trig_s1, trig_s2, trig_s3;
    logic            start;
    logic [AW-1:0]   idx;
    logic [AW-1:0]   last_idx;
    logic [AW-1:0]   last_idx_nxt;
    logic            phase;
    logic [DIVW-1:0] div_cnt;
    logic [DIVW-1:0] div_lat;
    logic            tick;

    // Two-flop synchroniser for trig plus one delay flop for edge detection.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            trig_s1 <= 1'b0;
            trig_s2 <= 1'b0;
            trig_s3 <= 1'b0;
        end else begin
            trig_s1 <= trig;
            trig_s2 <= trig_s1;
            trig_s3 <= trig_s2;
        end
    end

    assign start = trig_s2 & ~trig_s3;
    assign tick  = (state == S_RUN) && (div_cnt == div_lat);

    // Last word index of a pass, clamped so long requests stop at the memory end.
    always_comb begin
        last_idx_nxt = seq_length - 1'b1;
        if ({1'b0, seq_length} > DEPTH_W) begin
            last_idx_nxt = LAST_MAX;
        end
    end

    // Pattern memory: writes only while no sequence is playing, out-of-range dropped.
    always_ff @(posedge clk_in) begin
        if (wr_en && !busy && ({1'b0, wr_addr} < DEPTH_W)) begin
            mem[wr_addr[MW-1:0]] <= wr_data;
        end
    end

    // Sequencer FSM with registered outputs.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            clk      <= 1'b0;
            dout     <= '0;
            syn      <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            idx      <= '0;
            phase    <= 1'b0;
            div_cnt  <= '0;
            div_lat  <= '0;
            last_idx <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start && (seq_length != '0)) begin
                        state    <= S_RUN;
                        busy     <= 1'b1;
                        last_idx <= last_idx_nxt;
                        div_lat  <= div_base;
                        idx      <= '0;
                        phase    <= 1'b0;
                        div_cnt  <= '0;
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        state <= S_FINISH;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        div_cnt <= tick ? '0 : div_cnt + 1'b1;
                        if (tick) begin
                            if (!phase) begin
                                dout  <= mem[idx[MW-1:0]];
                                clk   <= 1'b0;
                                syn   <= (idx == '0);
                                phase <= 1'b1;
                            end else begin
                                // Rising clk edge; dout was set a half period earlier.
                                clk   <= 1'b1;
                                phase <= 1'b0;
                                if (idx == last_idx) begin
                                    if (loop_mode) begin
                                        idx <= '0;
                                    end else begin
                                        state <= S_FINISH;
                                        busy  <= 1'b0;
                                        done  <= 1'b1;
                                    end
                                end else begin
                                    idx <= idx + 1'b1;
                                end
                            end
                        end
                    end
                end
                S_FINISH: begin
                    clk   <= 1'b0;
                    syn   <= 1'b0;
                    done  <= 1'b0;
                    state <= S_IDLE;
                    if (clr_2_one) begin
                        dout <= '1;
                    end else if (clr_mode) begin
                        dout <= '0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dout_seq_gen.sv
// Bench for dout_seq_gen: table-driven runs, randomized runs against a
// word-list reference model, and hand-written multi-cycle corner cases.
module tb_dout_seq_gen;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AW    = 10;
    localparam int DIVW  = 5;

    logic            clk_in = 1'b0;
    logic            rst_n;
    logic            trig, abort, loop_mode, clr_mode, clr_2_one;
    logic [AW-1:0]   seq_length;
    logic [DIVW-1:0] div_base;
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [DW-1:0]   wr_data;
    logic            clk;
    logic [DW-1:0]   dout;
    logic            syn, busy, done;

    dout_seq_gen #(.DW(DW), .DEPTH(DEPTH), .AW(AW), .DIVW(DIVW)) dut (
        .clk_in(clk_in), .rst_n(rst_n), .trig(trig), .abort(abort),
        .loop_mode(loop_mode), .clr_mode(clr_mode), .clr_2_one(clr_2_one),
        .seq_length(seq_length), .div_base(div_base), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .clk(clk), .dout(dout),
        .syn(syn), .busy(busy), .done(done)
    );

    always #5 clk_in = ~clk_in;

    int errors = 0;
    int checks = 0;

    // Reference model: bench-side copy of the pattern memory.
    logic [DW-1:0] model_mem [DEPTH];

    // Capture of observed clk rising edges.
    logic [DW-1:0] cap_d[$];
    bit            cap_s[$];
    int            cap_t[$];
    int            done_cnt;
    bit            saw_busy;
    bit            prev_clk = 1'b0;
    int            cyc = 0;

    typedef struct {
        int          len;
        int          div;
        bit          c2o;
        bit          clr;
        int          n_words;
        int          period;
        logic [7:0]  fin;
    } vec_t;
    vec_t tbl[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk_in);
        cyc++;
        if (clk && !prev_clk) begin
            cap_d.push_back(dout);
            cap_s.push_back(syn);
            cap_t.push_back(cyc);
        end
        prev_clk = clk;
        if (done) done_cnt++;
        if (busy) saw_busy = 1'b1;
    endtask

    task automatic clear_cap();
        cap_d.delete();
        cap_s.delete();
        cap_t.delete();
        done_cnt = 0;
        saw_busy = 1'b0;
    endtask

    task automatic mem_write(input int addr, input logic [7:0] data, input bit accept);
        wr_addr = AW'(addr);
        wr_data = data;
        wr_en   = 1'b1;
        step();
        wr_en   = 1'b0;
        if (accept && addr < DEPTH) model_mem[addr] = data;
    endtask

    task automatic pulse_trig();
        trig = 1'b1;
        step();
        step();
        trig = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            step();
            n++;
        end
        check({tag, "_done_seen"}, (done_cnt != 0), 1);
        step();
        step();
    endtask

    task automatic do_run(input string tag, input int len, input int dv, input bit c2o, input bit clr);
        seq_length = AW'(len);
        div_base   = DIVW'(dv);
        clr_2_one  = c2o;
        clr_mode   = clr;
        clear_cap();
        pulse_trig();
        wait_done(tag, 1000);
    endtask

    task automatic check_run(input string tag, input int exp_n, input int period, input logic [7:0] fin);
        check({tag, "_busy_seen"}, saw_busy, 1);
        check({tag, "_edges"}, cap_d.size(), exp_n);
        for (int i = 0; i < cap_d.size() && i < exp_n; i++) begin
            check($sformatf("%s_word%0d", tag, i), cap_d[i], model_mem[i]);
            check($sformatf("%s_syn%0d", tag, i), cap_s[i], (i == 0));
            if (i > 0) check($sformatf("%s_period%0d", tag, i), cap_t[i] - cap_t[i-1], period);
        end
        check({tag, "_done_cnt"}, done_cnt, 1);
        check({tag, "_busy_end"}, busy, 0);
        check({tag, "_clk_end"}, clk, 0);
        check({tag, "_dout_end"}, dout, fin);
    endtask

    task automatic load_pattern();
        for (int i = 0; i < DEPTH; i++) mem_write(i, 8'(((i + 1) % 16) * 17), 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, len, dv, nexp;
        bit c2o, clr;
        logic [7:0] fin;

        // len, div, clr_2_one, clr_mode, words, bit period, final dout
        tbl[0] = '{4,  0, 1'b0, 1'b0, 4,  2, 8'h44};
        tbl[1] = '{4,  3, 1'b1, 1'b0, 4,  8, 8'hFF};
        tbl[2] = '{40, 0, 1'b0, 1'b1, 16, 2, 8'h00};
        tbl[3] = '{1,  1, 1'b0, 1'b0, 1,  4, 8'h11};
        tbl[4] = '{16, 2, 1'b1, 1'b1, 16, 6, 8'hFF};
        tbl[5] = '{3,  0, 1'b0, 1'b0, 3,  2, 8'h33};

        rst_n = 1'b0; trig = 0; abort = 0; loop_mode = 0; clr_mode = 0; clr_2_one = 0;
        seq_length = '0; div_base = '0; wr_en = 0; wr_addr = '0; wr_data = '0;
        clear_cap();
        step();
        step();
        check("rst_clk", clk, 0);
        check("rst_dout", dout, 0);
        check("rst_syn", syn, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rst_n = 1'b1;
        step();

        load_pattern();
        for (int t = 0; t < 6; t++) begin
            do_run($sformatf("tbl%0d", t), tbl[t].len, tbl[t].div, tbl[t].c2o, tbl[t].clr);
            check_run($sformatf("tbl%0d", t), tbl[t].n_words, tbl[t].period, tbl[t].fin);
        end

        // Zero length: start ignored.
        seq_length = '0;
        clear_cap();
        pulse_trig();
        repeat (20) step();
        check("len0_busy", saw_busy, 0);
        check("len0_edges", cap_d.size(), 0);
        check("len0_done", done_cnt, 0);

        // Write while busy dropped, second trig mid-run ignored.
        seq_length = AW'(4); div_base = DIVW'(3); clr_2_one = 0; clr_mode = 0;
        clear_cap();
        pulse_trig();
        n = 0;
        while (!busy && n < 50) begin step(); n++; end
        mem_write(2, 8'hEE, 1'b0);
        n = 0;
        while (cap_d.size() < 1 && n < 100) begin step(); n++; end
        pulse_trig();
        wait_done("busywr", 1000);
        check_run("busywr", 4, 8, 8'h44);
        repeat (30) step();
        check("busywr_no_restart", cap_d.size(), 4);
        check("busywr_idle", busy, 0);

        // Looping with abort.
        mem_write(0, 8'hA5, 1'b1);
        mem_write(1, 8'h5A, 1'b1);
        loop_mode = 1; seq_length = AW'(2); div_base = '0; clr_mode = 1; clr_2_one = 0;
        clear_cap();
        pulse_trig();
        n = 0;
        while (cap_d.size() < 6 && n < 500) begin step(); n++; end
        check("loop_edges", cap_d.size(), 6);
        abort = 1'b1;
        step();
        check("abort_done_next", done, 1);
        check("abort_busy_next", busy, 0);
        abort = 1'b0;
        loop_mode = 0;
        step();
        check("abort_dout_clr", dout, 8'h00);
        check("abort_clk", clk, 0);
        check("abort_done_cnt", done_cnt, 1);
        for (int i = 0; i < cap_d.size() && i < 6; i++) begin
            check($sformatf("loop_word%0d", i), cap_d[i], (i % 2 == 0) ? 8'hA5 : 8'h5A);
            check($sformatf("loop_syn%0d", i), cap_s[i], (i % 2 == 0));
        end
        clr_mode = 0;

        // Reset mid-sequence.
        load_pattern();
        seq_length = AW'(4); div_base = DIVW'(1);
        clear_cap();
        pulse_trig();
        n = 0;
        while (cap_d.size() < 2 && n < 200) begin step(); n++; end
        step();
        step();
        rst_n = 1'b0;
        #1;
        check("midrst_clk", clk, 0);
        check("midrst_dout", dout, 0);
        check("midrst_syn", syn, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        repeat (3) step();
        rst_n = 1'b1;
        repeat (5) step();
        check("midrst_no_done", done_cnt, 0);
        do_run("restart", 4, 1, 1'b0, 1'b0);
        check_run("restart", 4, 4, 8'h44);

        // Randomized runs against the word-list model.
        for (int r = 0; r < 10; r++) begin
            for (int i = 0; i < DEPTH; i++) mem_write(i, 8'($urandom), 1'b1);
            mem_write(DEPTH + $urandom_range(0, 1007), 8'($urandom), 1'b1);
            len = $urandom_range(1, 24);
            dv  = $urandom_range(0, 3);
            c2o = 1'($urandom);
            clr = 1'($urandom);
            nexp = (len > DEPTH) ? DEPTH : len;
            fin = c2o ? 8'hFF : (clr ? 8'h00 : model_mem[nexp-1]);
            do_run($sformatf("rnd%0d", r), len, dv, c2o, clr);
            check_run($sformatf("rnd%0d", r), nexp, 2 * (dv + 1), fin);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
